// File: rtl/rv32_pkg.sv
// Shared RV32I load/store definitions: funct3 width codes, LSU state encoding and the access legality check.
package rv32_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_WAIT_RD = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    // Legal width code for the direction, and naturally aligned for that width
    function automatic logic access_ok(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = ~we;
            F3_HU:   ok = ~we & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes and data replication, load lane extraction with sign/zero extension.
module lsu_align
    import rv32_pkg::*;
(
    input  logic [2:0]      st_funct3,
    input  logic [1:0]      st_offset,
    input  logic [XLEN-1:0] st_data,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_offset,
    input  logic [XLEN-1:0] ld_word,
    output logic [3:0]      wstrb,
    output logic [XLEN-1:0] wdata_rep,
    output logic [XLEN-1:0] load_data
);

    logic [15:0] lane;

    always_comb begin
        wstrb     = 4'b0000;
        wdata_rep = '0;
        case (st_funct3)
            F3_B: begin
                wstrb     = 4'b0001 << st_offset;
                wdata_rep = {4{st_data[7:0]}};
            end
            F3_H: begin
                wstrb     = 4'b0011 << st_offset;
                wdata_rep = {2{st_data[15:0]}};
            end
            F3_W: begin
                wstrb     = 4'b1111;
                wdata_rep = st_data;
            end
            default: ;
        endcase
    end

    // Only the low halfword of the shifted word is ever needed for sub-word loads
    always_comb begin
        lane      = 16'(ld_word >> {ld_offset, 3'b000});
        load_data = '0;
        case (ld_funct3)
            F3_B:    load_data = {{24{lane[7]}}, lane[7:0]};
            F3_H:    load_data = {{16{lane[15]}}, lane};
            F3_W:    load_data = ld_word;
            F3_BU:   load_data = {24'd0, lane[7:0]};
            F3_HU:   load_data = {16'd0, lane};
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding bus access per instruction with alignment checks and a bus timeout.
module load_store_unit
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]      state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic            err_nxt;
    logic [31:0]     rdata_nxt;
    logic            latch;
    logic            tmo;
    logic [3:0]      st_strb;
    logic [31:0]     st_rep;
    logic [31:0]     ld_fmt;

    lsu_align u_align (
        .st_funct3 (req_funct3),
        .st_offset (addr[1:0]),
        .st_data   (wdata),
        .ld_funct3 (f3_q),
        .ld_offset (off_q),
        .ld_word   (bus_rdata),
        .wstrb     (st_strb),
        .wdata_rep (st_rep),
        .load_data (ld_fmt)
    );

    assign stall = req_valid & ~done;
    assign tmo   = (cnt == CW'(TIMEOUT_CYCLES - 1));

    // Next-state, counter and result selection
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = 1'b0;
        rdata_nxt = rdata;
        latch     = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    latch = 1'b1;
                    if (access_ok(req_we, req_funct3, addr[1:0])) begin
                        state_nxt = S_REQ;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = S_DONE;
                        err_nxt   = 1'b1;
                        rdata_nxt = '0;
                    end
                end
            end
            S_REQ: begin
                cnt_nxt = cnt + CW'(1);
                if (bus_ready) begin
                    if (bus_we) begin
                        state_nxt = S_DONE;
                        rdata_nxt = '0;
                    end else begin
                        state_nxt = S_WAIT_RD;
                    end
                end else if (tmo) begin
                    state_nxt = S_DONE;
                    err_nxt   = 1'b1;
                    rdata_nxt = '0;
                end
            end
            S_WAIT_RD: begin
                cnt_nxt = cnt + CW'(1);
                if (bus_rvalid) begin
                    state_nxt = S_DONE;
                    rdata_nxt = ld_fmt;
                end else if (tmo) begin
                    state_nxt = S_DONE;
                    err_nxt   = 1'b1;
                    rdata_nxt = '0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, counter, latched request fields and registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wstrb <= '0;
            bus_wdata <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            done      <= (state_nxt == S_DONE);
            err       <= err_nxt;
            rdata     <= rdata_nxt;
            bus_valid <= (state_nxt == S_REQ);
            if (latch) begin
                f3_q      <= req_funct3;
                off_q     <= addr[1:0];
                bus_we    <= req_we;
                bus_addr  <= {addr[31:2], 2'b00};
                bus_wstrb <= req_we ? st_strb : 4'b0000;
                bus_wdata <= req_we ? st_rep : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a scoreboard of expected completions.
module tb_load_store_unit;
    import rv32_pkg::*;

    localparam int unsigned TMO = 4;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wstrb  (bus_wstrb),
        .bus_wdata  (bus_wdata),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One access: drives the request, plays a simple bus slave, checks the completion against the scoreboard
    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic rdy,
                          input logic [31:0] word, input logic exp_bus, input logic [3:0] exp_strb,
                          input logic [31:0] exp_bwd, input logic e_err, input logic [31:0] e_rd,
                          input int e_lat);
        exp_t e;
        logic saw_valid;
        logic prev_acc;
        logic got;
        int   cyc;
        saw_valid = 1'b0;
        prev_acc  = 1'b0;
        got       = 1'b0;
        cyc       = 0;
        e.err     = e_err;
        e.rdata   = e_rd;
        e.lat     = 8'(e_lat);
        sb.push_back(e);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        addr       = a;
        wdata      = wd;
        for (int i = 0; i < 30 && !got; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            bus_ready  = 1'b0;
            bus_rvalid = 1'b0;
            if (done) begin
                got = 1'b1;
                e   = sb.pop_front();
                check({tag, "_err"}, 32'(err), 32'(e.err));
                check({tag, "_rdata"}, rdata, e.rdata);
                check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
                check({tag, "_stall_at_done"}, 32'(stall), 32'd0);
                check({tag, "_bus_valid_at_done"}, 32'(bus_valid), 32'd0);
            end else begin
                check({tag, "_stall"}, 32'(stall), 32'd1);
                if (prev_acc && !we) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = word;
                end
                prev_acc = 1'b0;
                if (bus_valid) begin
                    check({tag, "_bus_addr"}, bus_addr, {a[31:2], 2'b00});
                    check({tag, "_bus_we"}, 32'(bus_we), 32'(we));
                    check({tag, "_bus_wstrb"}, 32'(bus_wstrb), 32'(exp_strb));
                    if (we) check({tag, "_bus_wdata"}, bus_wdata, exp_bwd);
                    saw_valid = 1'b1;
                    bus_ready = rdy;
                    prev_acc  = rdy;
                end
            end
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        if (!got && sb.size() > 0) e = sb.pop_front();
        check({tag, "_bus_valid_seen"}, 32'(saw_valid), 32'(exp_bus));
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        // req_valid stays high through the DONE cycle and must not start another access
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_no_restart"}, 32'(bus_valid), 32'd0);
        check({tag, "_rdata_hold"}, rdata, e_rd);
        req_valid = 1'b0;
    endtask

    initial begin
        rstn       = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = F3_W;
        addr       = 32'h0;
        wdata      = 32'h0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_stall_follows_req", 32'(stall), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_bus_valid", 32'(bus_valid), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        req_valid = 1'b0;
        #1;
        check("rst_stall_idle", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        //     tag        we    f3     addr          wdata         rdy   word          bus   strb     bwdata        err   rdata         lat
        access("sw",      1'b1, F3_W,  32'h0000_0100, 32'hDEADBEEF, 1'b1, 32'h0,        1'b1, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0,        2);
        access("lb",      1'b0, F3_B,  32'h0000_0203, 32'h0,        1'b1, 32'h80FF1234, 1'b1, 4'b0000, 32'h0,        1'b0, 32'hFFFFFF80, 3);
        access("lbu",     1'b0, F3_BU, 32'h0000_0203, 32'h0,        1'b1, 32'h80FF1234, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h00000080, 3);
        access("sh",      1'b1, F3_H,  32'h0000_0302, 32'h0000ABCD, 1'b1, 32'h0,        1'b1, 4'b1100, 32'hABCDABCD, 1'b0, 32'h0,        2);
        access("lh_mis",  1'b0, F3_H,  32'h0000_0301, 32'h0,        1'b1, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b1, 32'h0,        1);
        access("lw",      1'b0, F3_W,  32'h0000_0500, 32'h0,        1'b1, 32'h12345678, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h12345678, 3);
        access("lw_tmo",  1'b0, F3_W,  32'h0000_0504, 32'h0,        1'b0, 32'h0,        1'b1, 4'b0000, 32'h0,        1'b1, 32'h0,        5);
        access("sb",      1'b1, F3_B,  32'h0000_0105, 32'h1234565A, 1'b1, 32'h0,        1'b1, 4'b0010, 32'h5A5A5A5A, 1'b0, 32'h0,        2);
        access("f3_011",  1'b0, 3'b011,32'h0000_0600, 32'h0,        1'b1, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b1, 32'h0,        1);
        access("sbu_ill", 1'b1, F3_BU, 32'h0000_0600, 32'h0,        1'b1, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b1, 32'h0,        1);
        access("sw_mis",  1'b1, F3_W,  32'h0000_0602, 32'h0,        1'b1, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b1, 32'h0,        1);
        access("lhu",     1'b0, F3_HU, 32'h0000_0202, 32'h0,        1'b1, 32'h80017777, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h00008001, 3);
        access("lh",      1'b0, F3_H,  32'h0000_0202, 32'h0,        1'b1, 32'h80017777, 1'b1, 4'b0000, 32'h0,        1'b0, 32'hFFFF8001, 3);

        // Reset while waiting for read data; the late rvalid must be ignored
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = F3_W;
        addr       = 32'h0000_0400;
        @(posedge clk);
        #1;
        check("rstmid_req", 32'(bus_valid), 32'd1);
        bus_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_wait_rd", 32'(bus_valid), 32'd0);
        bus_ready = 1'b0;
        rstn      = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_rdata", rdata, 32'd0);
        check("rstmid_stall", 32'(stall), 32'd1);
        rstn       = 1'b1;
        req_valid  = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h11223344;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("late_rvalid_done", 32'(done), 32'd0);
            check("late_rvalid_bus_valid", 32'(bus_valid), 32'd0);
            check("late_rvalid_rdata", rdata, 32'd0);
        end
        bus_rvalid = 1'b0;

        access("sw_after_rst", 1'b1, F3_W, 32'h0000_0700, 32'hCAFEF00D, 1'b1, 32'h0, 1'b1, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0, 2);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
